// File: rtl/nco_quad_fold.sv
// nco_quad_fold: phase accumulator, quarter-wave fold and sign restore
// around an external quarter-wave sine stage.
//
//   stage 0 : acc + i_poff -> ph (combinational), acc steps by i_ftw
//   stage 1 : ph folded into a 16-bit quarter-wave phase on o_qph
//   stage 2 : i_sin (combinational from o_qph) gets its sign back
//
// Sample latency is two edges from an enabled edge to o_valid.
module nco_quad_fold #(
    parameter int ACC_W = 32  // fixed; fold needs at least 18 bits
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_sync,
    input  logic [ACC_W-1:0]        i_ftw,
    input  logic [ACC_W-1:0]        i_poff,
    output logic [15:0]             o_qph,
    input  logic [15:0]             i_sin,
    output logic signed [16:0]      o_wave,
    output logic                    o_valid
);

    localparam int QPH_W  = 16;
    localparam int STAGES = 2;
    // lowest phase bit that reaches the quarter-wave index
    localparam int QLSB   = ACC_W - 2 - QPH_W;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  ph;
    logic [QPH_W-1:0]  q;
    logic [1:0]        quad1;
    logic [STAGES:1]   vld_pipe;
    logic signed [16:0] mag;
    logic              ph_unused;

    // stage 0: sync restarts the accumulator at zero for this very sample,
    // so the offset alone forms the phase and the step builds from zero
    always_comb begin
        base = i_sync ? '0 : acc;
        ph   = base + i_poff;
        q    = ph[ACC_W-3 -: QPH_W];
    end

    // sub-LSB phase bits only feed carries into the index bits
    assign ph_unused = ^ph[QLSB-1:0];

    // stage 0 register: accumulator steps once per requested sample, wraps mod 2^ACC_W
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            acc <= '0;
        else if (i_en)
            acc <= base + i_ftw;
    end

    // stage 1: odd quadrants run backwards through the quarter wave
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_qph <= '0;
            quad1 <= '0;
        end else if (i_en) begin
            o_qph <= ph[ACC_W-2] ? ~q : q;
            quad1 <= ph[ACC_W-1 -: 2];
        end
    end

    // sample strobe follows the request down the pipe, gaps included
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], i_en};
    end

    // unsigned magnitude widened so -65535 fits without saturation
    assign mag = $signed({1'b0, i_sin});

    // stage 2: lower half-wave (quadrants 2,3) is the negated magnitude
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_wave <= '0;
        else if (vld_pipe[1])
            o_wave <= quad1[1] ? -mag : mag;
    end

    assign o_valid = vld_pipe[STAGES];

endmodule
